wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the in-order pipeline writeback result (WB stage output);
  - a multi-cycle unit (long-latency loads/multiply) with a valid/ready interface.
- Buffers multi-cycle results in a small FIFO.
- Gives the pipeline priority, with a starvation guard that stalls the pipeline.
- Squashes stale buffered writes and exports a pending-destination mask to the hazard unit.

Parameters:
- WORD_LEN, 32, data width (`WORD_LEN from defines.v)
- REG_ADDR_LEN, 4, register address width (16 registers)
- DEPTH, 2, multi-cycle result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles a FIFO head may wait before the pipeline is stalled

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pipe_wb_en  in  1  pipeline requests a write this cycle
- pipe_dest  in  REG_ADDR_LEN  pipeline destination register
- pipe_value  in  WORD_LEN  pipeline write data (WB_res)
- mc_valid  in  1  multi-cycle unit offers a result
- mc_ready  out  1  FIFO can accept (count < DEPTH)
- mc_dest  in  REG_ADDR_LEN  multi-cycle destination register
- mc_value  in  WORD_LEN  multi-cycle result
- rf_wr_en  out  1  register-file write enable
- rf_wr_dest  out  REG_ADDR_LEN  write address
- rf_wr_value  out  WORD_LEN  write data
- rf_wr_src  out  1  0 = pipeline, 1 = multi-cycle
- stall_pipe  out  1  pipeline must hold WB/MEM this cycle
- pending_busy  out  2**REG_ADDR_LEN  bit i set when a valid buffered entry targets register i
- fifo_count  out  clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (rst=0, async):
  - FIFO flushed; starve_cnt = 0.
  - All outputs 0, including mc_ready.
  - Buffered writes are discarded; reset mid-operation loses them by design.
- Push:
  - Accept when mc_valid && mc_ready.
  - mc_ready is derived from the registered count only, so there is no push on a full FIFO even if a pop happens the same cycle.
  - The entry is written valid=1.
- Head state: FIFO non-empty; head valid or squashed.
- Grant (combinational, same-cycle write, zero latency):
  1. stall_pipe=1 and head valid -> grant head; pipe_wb_en ignored (pipeline re-presents next cycle).
  2. else pipe_wb_en=1 -> grant pipeline.
  3. else head valid -> grant head.
  4. else rf_wr_en=0.
- Pop:
  - A granted head pops at the clock edge.
  - A squashed (invalid) head pops unconditionally that cycle without using the write port.
- stall_pipe = head valid && starve_cnt >= STARVE_LIMIT (starve_cnt registered; no combinational loop through pipe_wb_en).
- starve_cnt:
  - cleared when the head is granted, the head is squashed, or the FIFO is empty;
  - otherwise +1 per cycle, saturating at STARVE_LIMIT.
- Squash:
  - When the pipeline is granted with dest d, every buffered valid entry with dest d is cleared at the edge; the pipeline write is newer.
  - An entry pushed in that same cycle with dest d is NOT squashed; it is newer than the pipeline write.
  - If the head is granted (stall case) while the pipeline presents the same dest, no squash occurs; the pipeline is not granted.
- pending_busy: OR over valid entries of one-hot(dest); squashed entries excluded. Combinational from FIFO state.
- fifo_count includes squashed entries until they pop.
- Pointers wrap modulo DEPTH; simultaneous push+pop keeps the count unchanged.

Decomposition:
- Add to defines.v:
  - `REG_FILE_ADDR_LEN (4)
  - `WB_SRC_PIPE (1'b0), `WB_SRC_MC (1'b1)
  - `WB_FIFO_DEPTH (2), `WB_STARVE_LIMIT (4)
- Sub-module wb_fifo: circular buffer with per-entry valid bit.
  - Inputs: push, pop, squash-by-dest.
  - Outputs: head, count, pending mask.
- The arbiter top holds grant logic and the starvation counter.

Test Plan:
- Reset mid-operation:
  - Stimulus: push 2 entries, assert rst=0 mid-cycle.
  - Required: immediately fifo_count=0, mc_ready=0, rf_wr_en=0, pending_busy=0.
  - After release: mc_ready=1.
- Idle pipeline:
  - Stimulus: mc push dest=3 value=0xDEADBEEF, pipe_wb_en=0.
  - Required: next cycle rf_wr_en=1, rf_wr_dest=3, rf_wr_value=0xDEADBEEF, rf_wr_src=1; then fifo_count=0.
- Pipeline priority:
  - Stimulus: pipe_wb_en=1 (dest=5, 0x11) with buffered head dest=7.
  - Required: rf_wr_src=0, dest=5; head remains, pending_busy[7]=1.
- Starvation:
  - Stimulus: pipe_wb_en=1 continuously with head buffered.
  - Required: after 4 cycles stall_pipe=1, head written (rf_wr_src=1); next cycle stall_pipe=0, pipeline granted.
- Squash:
  - Stimulus: buffer dest=2 value=0xAA; pipeline writes dest=2 value=0xBB.
  - Required: reg2 written 0xBB only; next cycle the squashed head pops with rf_wr_en=0; pending_busy[2]=0.
- Same-cycle push and squash:
  - Stimulus: push dest=2 in the same cycle as pipeline write dest=2.
  - Required: new entry kept and later written.
- Full FIFO:
  - Stimulus: two pushes, pipeline busy.
  - Required: mc_ready=0; a third mc_valid is held (not accepted) until a pop.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Widths and source encodings used by the arbiter and its result FIFO.
package wb_port_arbiter_pkg;

    localparam int   WB_WORD_LEN       = 32;
    localparam int   REG_FILE_ADDR_LEN = 4;
    localparam int   WB_FIFO_DEPTH     = 2;
    localparam int   WB_STARVE_LIMIT   = 4;

    localparam logic WB_SRC_PIPE = 1'b0;
    localparam logic WB_SRC_MC   = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_HEAD = 2'd2
    } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of multi-cycle results with a per-entry valid bit.
// Entries can be squashed by destination and still occupy a slot until they pop.
module wb_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int WORD_LEN     = WB_WORD_LEN,
    parameter int REG_ADDR_LEN = REG_FILE_ADDR_LEN,
    parameter int DEPTH        = WB_FIFO_DEPTH,
    localparam int PTR_W       = $clog2(DEPTH),
    localparam int CNT_W       = $clog2(DEPTH) + 1,
    localparam int NREGS       = 2 ** REG_ADDR_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [REG_ADDR_LEN-1:0] push_dest,
    input  logic [WORD_LEN-1:0]     push_value,
    input  logic                    pop,
    input  logic                    squash,
    input  logic [REG_ADDR_LEN-1:0] squash_dest,
    output logic                    head_present,
    output logic                    head_valid,
    output logic [REG_ADDR_LEN-1:0] head_dest,
    output logic [WORD_LEN-1:0]     head_value,
    output logic [CNT_W-1:0]        count,
    output logic [NREGS-1:0]        pending
);

    logic                    ent_vld   [DEPTH];
    logic [REG_ADDR_LEN-1:0] ent_dest  [DEPTH];
    logic [WORD_LEN-1:0]     ent_value [DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;

    // A fresh push wins over a same-cycle squash: it is newer than the pipeline write.
    // Pop clears the valid bit so unoccupied slots never contribute to the pending mask.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ent_vld[i]   <= 1'b0;
                ent_dest[i]  <= '0;
                ent_value[i] <= '0;
            end else if (push && wr_ptr == PTR_W'(i)) begin
                ent_vld[i]   <= 1'b1;
                ent_dest[i]  <= push_dest;
                ent_value[i] <= push_value;
            end else if (pop && rd_ptr == PTR_W'(i)) begin
                ent_vld[i]   <= 1'b0;
            end else if (squash && ent_dest[i] == squash_dest) begin
                ent_vld[i]   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_present = (count != '0);
    assign head_valid   = head_present && ent_vld[rd_ptr];
    assign head_dest    = ent_dest[rd_ptr];
    assign head_value   = ent_value[rd_ptr];

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ent_vld[i]) pending[ent_dest[i]] = 1'b1;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and buffered
// multi-cycle results: pipeline first, with a starvation guard that stalls the pipeline.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int WORD_LEN     = WB_WORD_LEN,
    parameter int REG_ADDR_LEN = REG_FILE_ADDR_LEN,
    parameter int DEPTH        = WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT,
    localparam int CNT_W       = $clog2(DEPTH) + 1,
    localparam int SC_W        = $clog2(STARVE_LIMIT + 1),
    localparam int NREGS       = 2 ** REG_ADDR_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pipe_wb_en,
    input  logic [REG_ADDR_LEN-1:0] pipe_dest,
    input  logic [WORD_LEN-1:0]     pipe_value,
    input  logic                    mc_valid,
    output logic                    mc_ready,
    input  logic [REG_ADDR_LEN-1:0] mc_dest,
    input  logic [WORD_LEN-1:0]     mc_value,
    output logic                    rf_wr_en,
    output logic [REG_ADDR_LEN-1:0] rf_wr_dest,
    output logic [WORD_LEN-1:0]     rf_wr_value,
    output logic                    rf_wr_src,
    output logic                    stall_pipe,
    output logic [NREGS-1:0]        pending_busy,
    output logic [CNT_W-1:0]        fifo_count
);

    logic                    run_q;
    logic [SC_W-1:0]         starve_cnt;
    grant_e                  grant;
    logic                    head_present;
    logic                    head_valid;
    logic [REG_ADDR_LEN-1:0] head_dest;
    logic [WORD_LEN-1:0]     head_value;
    logic                    push;
    logic                    pop;
    logic                    squash_pop;

    // Holds every output quiet during reset and the first cycle after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_q <= 1'b0;
        else      run_q <= 1'b1;
    end

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
    assign mc_ready   = run_q && (fifo_count < CNT_W'(DEPTH));
    assign push       = mc_valid && mc_ready;
    assign stall_pipe = run_q && head_valid && (starve_cnt >= SC_W'(STARVE_LIMIT));

    always_comb begin
        grant = GNT_NONE;
        if (run_q) begin
            if (stall_pipe)      grant = GNT_HEAD;
            else if (pipe_wb_en) grant = GNT_PIPE;
            else if (head_valid) grant = GNT_HEAD;
        end
    end

    assign squash_pop = run_q && head_present && !head_valid;
    assign pop        = (grant == GNT_HEAD) || squash_pop;

    always_comb begin
        rf_wr_en    = 1'b0;
        rf_wr_dest  = '0;
        rf_wr_value = '0;
        rf_wr_src   = WB_SRC_PIPE;
        case (grant)
            GNT_PIPE: begin
                rf_wr_en    = 1'b1;
                rf_wr_dest  = pipe_dest;
                rf_wr_value = pipe_value;
                rf_wr_src   = WB_SRC_PIPE;
            end
            GNT_HEAD: begin
                rf_wr_en    = 1'b1;
                rf_wr_dest  = head_dest;
                rf_wr_value = head_value;
                rf_wr_src   = WB_SRC_MC;
            end
            default: ;
        endcase
    end

    // Counts cycles a valid head is passed over; empty or squashed heads reset it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            starve_cnt <= '0;
        else if (grant == GNT_HEAD || !head_valid)
            starve_cnt <= '0;
        else if (starve_cnt < SC_W'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + SC_W'(1);
    end

    wb_fifo #(
        .WORD_LEN     (WORD_LEN),
        .REG_ADDR_LEN (REG_ADDR_LEN),
        .DEPTH        (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .push_dest    (mc_dest),
        .push_value   (mc_value),
        .pop          (pop),
        .squash       (grant == GNT_PIPE),
        .squash_dest  (pipe_dest),
        .head_present (head_present),
        .head_valid   (head_valid),
        .head_dest    (head_dest),
        .head_value   (head_value),
        .count        (fifo_count),
        .pending      (pending_busy)
    );

endmodule
